// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the MIPS core.
//   - Combinational per-stage stall vector built from per-stage stall requests;
//     a flush overrides any stall.
//   - Accepts one exception/ERET event from the MEM stage while idle, latches
//     its code and redirect target, drives flush_o for FLUSH_CYCLES cycles and
//     then pulses redirect_o for one cycle.
//   - Watchdog counting consecutive idle stall cycles with a sticky timeout flag.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall_req         per-stage stall request (bit 0 = PC, STAGES-1 = WB)
//   exc_valid_i       exception/ERET event present this cycle
//   execode_i         cause code (0 = no event)
//   cp0_epc_i         EPC, used as the target for ERET
//   stall_o           per-stage hold
//   flush_o           clear all pipeline registers
//   redirect_o        one-cycle pulse, PC loads new_pc_o
//   new_pc_o          redirect target, held until the next accepted event
//   exc_code_o        code of the last accepted event
//   busy_o            controller is flushing or redirecting
//   stall_timeout_o   sticky watchdog flag
module pipe_ctrl #(
  parameter int          STAGES        = 6,
  parameter logic [31:0] EXC_BASE      = 32'h8000_0000,
  parameter logic [31:0] INT_OFFSET    = 32'h4,
  parameter logic [31:0] RI_OFFSET     = 32'h8,
  parameter logic [31:0] GEN_OFFSET    = 32'h4,
  parameter int          FLUSH_CYCLES  = 2,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] stall_req,
  input  logic              exc_valid_i,
  input  logic [3:0]        execode_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic              redirect_o,
  output logic [31:0]       new_pc_o,
  output logic [3:0]        exc_code_o,
  output logic              busy_o,
  output logic              stall_timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIR} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(STALL_TIMEOUT - 1);
  localparam logic [3:0]       FL_LOAD = 4'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [3:0]        exc_code_q, exc_code_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              timeout_q, timeout_d;
  logic              accept;
  logic              stall_any;
  logic [STAGES-1:0] stall_vec;

  // Vector target for an accepted event; sums wrap modulo 2^32.
  function automatic logic [31:0] target(input logic [3:0] code, input logic [31:0] epc);
    case (code)
      4'h1, 4'hc, 4'hd: target = EXC_BASE + INT_OFFSET;
      4'ha:             target = EXC_BASE + RI_OFFSET;
      4'he:             target = epc;
      default:          target = EXC_BASE + GEN_OFFSET;
    endcase
  endfunction

  assign stall_any = |stall_req;
  // Events seen outside IDLE belong to wrong-path instructions and are dropped.
  assign accept    = (state_q == S_IDLE) && exc_valid_i && (execode_i != 4'h0);

  // A request from stage i holds stage i and every earlier stage.
  always_comb begin
    stall_vec = '0;
    stall_vec[STAGES-1] = stall_req[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      stall_vec[i] = stall_req[i] | stall_vec[i+1];
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    new_pc_d    = new_pc_q;
    exc_code_d  = exc_code_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_FLUSH;
          fcnt_d     = FL_LOAD;
          new_pc_d   = target(execode_i, cp0_epc_i);
          exc_code_d = execode_i;
        end
      end
      S_FLUSH: begin
        if (fcnt_q == 4'h0) state_d = S_REDIR;
        else                fcnt_d  = fcnt_q - 4'h1;
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Watchdog: counts only idle stall cycles, holds while busy, saturates.
    if (!stall_any || accept) begin
      stall_cnt_d = '0;
    end else if (state_q == S_IDLE && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (stall_any && stall_cnt_q == CNT_TO) timeout_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fcnt_q      <= '0;
      new_pc_q    <= '0;
      exc_code_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      new_pc_q    <= new_pc_d;
      exc_code_q  <= exc_code_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign flush_o         = (state_q == S_FLUSH);
  assign redirect_o      = (state_q == S_REDIR);
  assign busy_o          = (state_q != S_IDLE);
  assign new_pc_o        = new_pc_q;
  assign exc_code_o      = exc_code_q;
  assign stall_timeout_o = timeout_q;
  // Flush has priority over stall; nothing is held while reset is asserted.
  assign stall_o         = (flush_o || !rst_n) ? '0 : stall_vec;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// stimulus, all compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int STAGES = 6;
  localparam int FLUSH_CYCLES = 2;
  localparam int STALL_TIMEOUT = 8;
  localparam int CNT_W = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [STAGES-1:0] stall_req = '0;
  logic              exc_valid_i = 1'b0;
  logic [3:0]        execode_i = '0;
  logic [31:0]       cp0_epc_i = '0;
  logic [STAGES-1:0] stall_o;
  logic              flush_o, redirect_o, busy_o, stall_timeout_o;
  logic [31:0]       new_pc_o;
  logic [3:0]        exc_code_o;

  int checks = 0;
  int failures = 0;

  // Behavioural model state.
  int          m_flush_left;  // flush cycles still to come
  bit          m_redir;       // redirect cycle is current
  logic [31:0] m_pc;
  logic [3:0]  m_code;
  int          m_stall_cnt;
  bit          m_timeout;

  pipe_ctrl #(
    .STAGES(STAGES), .FLUSH_CYCLES(FLUSH_CYCLES),
    .STALL_TIMEOUT(STALL_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(stall_req),
    .exc_valid_i(exc_valid_i), .execode_i(execode_i), .cp0_epc_i(cp0_epc_i),
    .stall_o(stall_o), .flush_o(flush_o), .redirect_o(redirect_o),
    .new_pc_o(new_pc_o), .exc_code_o(exc_code_o), .busy_o(busy_o),
    .stall_timeout_o(stall_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_target(input logic [3:0] c, input logic [31:0] epc);
    if (c == 4'he) return epc;
    if (c == 4'ha) return 32'h8000_0008;
    return 32'h8000_0004;  // interrupt/trap/overflow and every other code
  endfunction

  function automatic bit model_idle();
    return (m_flush_left == 0) && !m_redir;
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_redir = 0; m_pc = '0; m_code = '0;
    m_stall_cnt = 0; m_timeout = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit idle, acc, any;
    idle = model_idle();
    any  = (stall_req != 0);
    acc  = idle && exc_valid_i && (execode_i != 0);
    if (any && m_stall_cnt == STALL_TIMEOUT - 1) m_timeout = 1;
    if (!any || acc)                  m_stall_cnt = 0;
    else if (idle && m_stall_cnt < CNT_SAT) m_stall_cnt++;
    if (m_redir) m_redir = 0;
    else if (m_flush_left > 0) begin
      m_flush_left--;
      if (m_flush_left == 0) m_redir = 1;
    end else if (acc) begin
      m_flush_left = FLUSH_CYCLES;
      m_pc = model_target(execode_i, cp0_epc_i);
      m_code = execode_i;
    end
  endtask

  task automatic compare_all();
    logic [STAGES-1:0] exp_stall;
    exp_stall = '0;
    for (int i = 0; i < STAGES; i++) exp_stall[i] = ((stall_req >> i) != 0);
    if (m_flush_left > 0 || !rst_n) exp_stall = '0;
    check("stall_o", 32'(stall_o), 32'(exp_stall));
    check("flush_o", 32'(flush_o), 32'(m_flush_left > 0));
    check("redirect_o", 32'(redirect_o), 32'(m_redir));
    check("busy_o", 32'(busy_o), 32'(!model_idle()));
    check("new_pc_o", new_pc_o, m_pc);
    check("exc_code_o", 32'(exc_code_o), 32'(m_code));
    check("stall_timeout_o", 32'(stall_timeout_o), 32'(m_timeout));
  endtask

  // Drive one cycle of inputs mid-cycle, check outputs, then step the model.
  task automatic cycle(input logic [STAGES-1:0] req, input logic v,
                       input logic [3:0] code, input logic [31:0] epc);
    @(negedge clk);
    stall_req = req; exc_valid_i = v; execode_i = code; cp0_epc_i = epc;
    #1;
    compare_all();
    @(posedge clk);
    model_step();
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    stall_req = '0; exc_valid_i = 1'b0; execode_i = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Stall vector shapes.
    cycle(6'b001000, 0, 4'h0, 0);
    check("stall_001000", 32'(stall_o), 32'h0f);
    cycle(6'b100001, 0, 4'h0, 0);
    check("stall_100001", 32'(stall_o), 32'h3f);

    // Reserved instruction: flush 2 cycles, then redirect to base+8.
    cycle(6'b000000, 1, 4'ha, 32'h1234_5678);
    repeat (4) cycle(6'b000000, 0, 4'h0, 0);
    #1;
    check("ri_pc", new_pc_o, 32'h8000_0008);
    check("ri_code", 32'(exc_code_o), 32'ha);
    check("ri_idle", 32'(busy_o), 32'h0);

    // ERET under a stall; a second event during flush is dropped.
    cycle(6'b000100, 1, 4'he, 32'h8000_0120);
    cycle(6'b000100, 1, 4'h1, 32'h0);
    check("eret_stall_masked", 32'(stall_o), 32'h0);
    repeat (3) cycle(6'b000100, 0, 4'h0, 0);
    #1;
    check("eret_pc", new_pc_o, 32'h8000_0120);
    check("eret_code", 32'(exc_code_o), 32'he);

    // Code 0 is ignored; code 7 uses the generic offset.
    cycle(6'b000000, 1, 4'h0, 32'hdead_beef);
    cycle(6'b000000, 0, 4'h0, 0);
    check("code0_no_flush", 32'(flush_o), 32'h0);
    cycle(6'b000000, 1, 4'h7, 0);
    repeat (4) cycle(6'b000000, 0, 4'h0, 0);
    #1;
    check("gen_pc", new_pc_o, 32'h8000_0004);

    // Watchdog: 8 stalled idle cycles set the flag; it survives until reset.
    do_reset();
    repeat (8) cycle(6'b000010, 0, 4'h0, 0);
    #1;
    check("timeout_set", 32'(stall_timeout_o), 32'h1);
    cycle(6'b000000, 0, 4'h0, 0);
    cycle(6'b000000, 0, 4'h0, 0);
    check("timeout_sticky", 32'(stall_timeout_o), 32'h1);
    do_reset();
    check("timeout_cleared", 32'(stall_timeout_o), 32'h0);

    // Reset during the second flush cycle aborts the flush.
    cycle(6'b000000, 1, 4'hd, 0);
    cycle(6'b000000, 0, 4'h0, 0);
    do_reset();
    check("abort_flush", 32'(flush_o), 32'h0);
    check("abort_pc", new_pc_o, 32'h0);
    repeat (4) begin
      cycle(6'b000000, 0, 4'h0, 0);
      check("abort_no_redirect", 32'(redirect_o), 32'h0);
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [STAGES-1:0] req;
      if ($urandom_range(0, 79) == 0) do_reset();
      req = ($urandom_range(0, 5) == 0) ? '0 : STAGES'($urandom);
      cycle(req, ($urandom_range(0, 2) == 0), 4'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
